cnt_monitor: RTL and testbench

Downstream observer for the signed up/down counter. It samples the counter's 10-bit signed `cnt` every clock and classifies each step as normal, jump, reversal, saturation or illegal. It tracks the running minimum and maximum, and queues classified events in a 4-deep FIFO drained over a valid/ready handshake. It shares the counter's clock and sits directly on its `cnt` output.

---
 rtl/cnt_monitor.sv | 150 +++++++++++++++
 tb/tb_cnt_monitor.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/cnt_monitor.sv
// Observer for the signed up/down counter: classifies each step of cnt,
// tracks the running min/max, and queues events in a 4-deep valid/ready FIFO.
module cnt_monitor #(
  parameter int UP_STEP  = 4,
  parameter int DN_STEP  = 10,
  parameter int HOLD_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic signed [9:0] cnt,
  input  logic              clear,
  input  logic              ev_ready,
  output logic              ev_valid,
  output logic [1:0]        ev_code,
  output logic signed [9:0] ev_value,
  output logic signed [9:0] min_val,
  output logic signed [9:0] max_val,
  output logic              overflow
);

  typedef enum logic [1:0] {INIT, FLAT, UP, DOWN} state_t;

  localparam logic [1:0] CODE_REV  = 2'd0;
  localparam logic [1:0] CODE_SAT  = 2'd1;
  localparam logic [1:0] CODE_SKIP = 2'd2;
  localparam logic [1:0] CODE_ERR  = 2'd3;

  localparam logic [10:0] D_UP1 = 11'(UP_STEP);
  localparam logic [10:0] D_UP2 = 11'(2 * UP_STEP);
  localparam logic [10:0] D_DN1 = 11'(-DN_STEP);
  localparam logic [10:0] D_DN2 = 11'(-2 * DN_STEP);
  localparam logic [2:0]  HOLD3 = 3'(HOLD_CYC);
  localparam logic [3:0]  HOLD4 = 4'(HOLD_CYC);

  state_t            state, state_nxt;
  logic signed [9:0] prev;
  logic [2:0]        flat_cnt;
  logic [10:0]       delta;
  logic              is_zero, is_pos, is_neg, legal, skip, rev, moving, hold_hit;
  logic              ev_fire;
  logic [1:0]        ev_sel;
  logic [9:0]        ev_sel_val;

  logic [11:0]       fifo_mem [4];
  logic [1:0]        rd_ptr, wr_ptr;
  logic [2:0]        count;
  logic              full, push, pop;

  // Sign-extend both operands so the 11-bit difference is exact.
  assign delta    = {cnt[9], cnt} - {prev[9], prev};
  assign is_zero  = (delta == 11'd0);
  assign is_neg   = delta[10];
  assign is_pos   = !is_zero && !delta[10];
  assign legal    = is_zero || delta == D_UP1 || delta == D_DN1 ||
                    delta == D_UP2 || delta == D_DN2;
  assign skip     = (delta == D_UP2) || (delta == D_DN2);
  assign moving   = (state == UP) || (state == DOWN);
  assign rev      = (state == UP && is_neg) || (state == DOWN && is_pos);
  assign hold_hit = is_zero && moving && (({1'b0, flat_cnt} + 4'd1) == HOLD4);

  always_comb begin
    state_nxt  = state;
    ev_fire    = 1'b0;
    ev_sel     = CODE_REV;
    ev_sel_val = cnt;
    if (state == INIT) begin
      state_nxt = FLAT;
    end else begin
      if (is_pos)        state_nxt = UP;
      else if (is_neg)   state_nxt = DOWN;
      else if (hold_hit) state_nxt = FLAT;

      if (!legal) begin
        ev_fire = 1'b1;
        ev_sel  = CODE_ERR;
      end else if (rev) begin
        ev_fire    = 1'b1;
        ev_sel     = CODE_REV;
        ev_sel_val = prev;
      end else if (skip) begin
        ev_fire = 1'b1;
        ev_sel  = CODE_SKIP;
      end else if (hold_hit) begin
        ev_fire = 1'b1;
        ev_sel  = CODE_SAT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= INIT;
      prev     <= '0;
      flat_cnt <= '0;
      min_val  <= '0;
      max_val  <= '0;
    end else if (clear) begin
      state    <= INIT;
      flat_cnt <= '0;
      min_val  <= '0;
      max_val  <= '0;
    end else begin
      state <= state_nxt;
      prev  <= cnt;
      if (state == INIT) begin
        min_val  <= cnt;
        max_val  <= cnt;
        flat_cnt <= '0;
      end else begin
        if (cnt < min_val) min_val <= cnt;
        if (cnt > max_val) max_val <= cnt;
        if (!is_zero)              flat_cnt <= '0;
        else if (flat_cnt < HOLD3) flat_cnt <= flat_cnt + 3'd1;
      end
    end
  end

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign full  = (count == 3'd4);
  assign pop   = ev_valid && ev_ready;
  assign push  = ev_fire && (!full || pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
    end else if (clear) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {ev_sel, ev_sel_val};
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b00, push} - {2'b00, pop};
      if (ev_fire && full && !pop) overflow <= 1'b1;
    end
  end

  assign ev_valid = (count != 3'd0);
  assign ev_code  = fifo_mem[rd_ptr][11:10];
  assign ev_value = fifo_mem[rd_ptr][9:0];

endmodule

// File: tb/tb_cnt_monitor.sv
// Scoreboard bench for cnt_monitor: expected events are queued as stimulus is
// driven and compared against every handshake pop of the DUT FIFO.
module tb_cnt_monitor;

  logic              clk;
  logic              rst;
  logic signed [9:0] cnt;
  logic              clear;
  logic              ev_ready;
  logic              ev_valid;
  logic [1:0]        ev_code;
  logic signed [9:0] ev_value;
  logic signed [9:0] min_val;
  logic signed [9:0] max_val;
  logic              overflow;

  int          check_cnt = 0;
  int          pass_cnt  = 0;
  logic [11:0] sb [$];
  logic [11:0] head;

  cnt_monitor #(.UP_STEP(4), .DN_STEP(10), .HOLD_CYC(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .cnt      (cnt),
    .clear    (clear),
    .ev_ready (ev_ready),
    .ev_valid (ev_valid),
    .ev_code  (ev_code),
    .ev_value (ev_value),
    .min_val  (min_val),
    .max_val  (max_val),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    check_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, $signed(obs), $signed(exp));
  endtask

  // Drive one sample just after an edge; return once the next edge has classified it.
  task automatic applyStimulus(input logic [9:0] v);
    cnt = v;
    @(posedge clk);
    #1;
  endtask

  task automatic expectEvent(input logic [1:0] code, input logic [9:0] value);
    sb.push_back({code, value});
  endtask

  // Inputs only change 1 ns after a rising edge, so a negedge sample sees exactly
  // what the next rising edge will pop.
  always @(negedge clk) begin
    if (rst && ev_valid && ev_ready) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_event", {9'd0, ev_valid}, 10'd0);
      end else begin
        head = sb.pop_front();
        checkOutput("pop_code", {8'd0, ev_code}, {8'd0, head[11:10]});
        checkOutput("pop_value", ev_value, head[9:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst      = 1'b0;
    cnt      = 10'sd17;
    clear    = 1'b0;
    ev_ready = 1'b1;
    #3;
    checkOutput("rst_ev_valid", {9'd0, ev_valid}, 10'd0);
    checkOutput("rst_ev_code",  {8'd0, ev_code},  10'd0);
    checkOutput("rst_ev_value", ev_value, 10'd0);
    checkOutput("rst_min", min_val, 10'd0);
    checkOutput("rst_max", max_val, 10'd0);
    checkOutput("rst_overflow", {9'd0, overflow}, 10'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    $display("[TB] hold 17");
    for (int i = 0; i < 4; i++) applyStimulus(10'(17));
    checkOutput("hold_ev_valid", {9'd0, ev_valid}, 10'd0);
    checkOutput("hold_min", min_val, 10'(17));
    checkOutput("hold_max", max_val, 10'(17));

    $display("[TB] reversal");
    applyStimulus(10'(21));
    applyStimulus(10'(25));
    expectEvent(2'd0, 10'(25));
    applyStimulus(10'(15));
    checkOutput("rev_valid", {9'd0, ev_valid}, 10'd1);
    checkOutput("rev_code",  {8'd0, ev_code},  10'd0);
    checkOutput("rev_value", ev_value, 10'(25));
    checkOutput("rev_max", max_val, 10'(25));
    checkOutput("rev_min", min_val, 10'(15));
    applyStimulus(10'(15));
    checkOutput("rev_drained", 10'(sb.size()), 10'd0);

    $display("[TB] skip");
    clear = 1'b1;
    applyStimulus(10'(-55));
    clear = 1'b0;
    checkOutput("clr_min", min_val, 10'd0);
    checkOutput("clr_max", max_val, 10'd0);
    applyStimulus(10'(-55));
    applyStimulus(10'(-51));
    expectEvent(2'd2, 10'(-43));
    applyStimulus(10'(-43));
    checkOutput("skip_code",  {8'd0, ev_code}, 10'd2);
    checkOutput("skip_value", ev_value, 10'(-43));
    applyStimulus(10'(-39));
    checkOutput("skip_after_valid", {9'd0, ev_valid}, 10'd0);
    checkOutput("skip_min", min_val, 10'(-55));
    checkOutput("skip_max", max_val, 10'(-39));

    $display("[TB] saturation");
    clear = 1'b1;
    applyStimulus(10'(261));
    clear = 1'b0;
    applyStimulus(10'(261));
    applyStimulus(10'(265));
    applyStimulus(10'(269));
    applyStimulus(10'(269));
    checkOutput("sat_early_valid", {9'd0, ev_valid}, 10'd0);
    expectEvent(2'd1, 10'(269));
    applyStimulus(10'(269));
    checkOutput("sat_valid", {9'd0, ev_valid}, 10'd1);
    checkOutput("sat_code",  {8'd0, ev_code},  10'd1);
    checkOutput("sat_value", ev_value, 10'(269));
    applyStimulus(10'(269));
    applyStimulus(10'(269));
    checkOutput("sat_once", {9'd0, ev_valid}, 10'd0);

    $display("[TB] overflow");
    ev_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) expectEvent(2'd3, 10'(269 + i));
      applyStimulus(10'(269 + i));
    end
    checkOutput("ovf_flag",  {9'd0, overflow}, 10'd1);
    checkOutput("ovf_valid", {9'd0, ev_valid}, 10'd1);
    checkOutput("ovf_head_code",  {8'd0, ev_code}, 10'd3);
    checkOutput("ovf_head_value", ev_value, 10'(270));
    ev_ready = 1'b1;
    for (int i = 1; i <= 4; i++) applyStimulus(10'(274 + 4 * i));
    checkOutput("drain_valid", {9'd0, ev_valid}, 10'd0);
    checkOutput("drain_sb", 10'(sb.size()), 10'd0);
    checkOutput("ovf_sticky", {9'd0, overflow}, 10'd1);
    clear = 1'b1;
    applyStimulus(10'(290));
    clear = 1'b0;
    checkOutput("clr_overflow", {9'd0, overflow}, 10'd0);
    checkOutput("clr_valid", {9'd0, ev_valid}, 10'd0);

    $display("[TB] async reset");
    ev_ready = 1'b0;
    applyStimulus(10'(100));
    applyStimulus(10'(101));
    applyStimulus(10'(102));
    checkOutput("pre_rst_valid", {9'd0, ev_valid}, 10'd1);
    #2 rst = 1'b0;
    #1;
    checkOutput("arst_valid", {9'd0, ev_valid}, 10'd0);
    checkOutput("arst_min", min_val, 10'd0);
    checkOutput("arst_max", max_val, 10'd0);
    #2 rst = 1'b1;
    ev_ready = 1'b1;
    applyStimulus(10'(102));
    checkOutput("reinit_valid", {9'd0, ev_valid}, 10'd0);
    checkOutput("reinit_min", min_val, 10'(102));
    checkOutput("reinit_max", max_val, 10'(102));
    applyStimulus(10'(106));
    checkOutput("reinit_up_valid", {9'd0, ev_valid}, 10'd0);
    checkOutput("reinit_up_max", max_val, 10'(106));
    checkOutput("final_sb", 10'(sb.size()), 10'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
